// File: rtl/mask_share_encoder.sv
// mask_share_encoder: splits a plain data word into d = security_order+1
// Boolean shares. Shares 1..d-1 are fresh random words. Share 0 is folded
// serially, one random word per cycle, so no single combinational cone ever
// combines the secret with every mask at once.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for in_valid; in_ready high
// ACCUM | folding one rnd word per accepted rnd_valid into acc; rnd_ready high
// HOLD  | out_shares presented with out_valid until out_ready
module mask_share_encoder #(
  parameter int security_order = 2,
  parameter int width          = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [width-1:0]                      in_data,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [width-1:0]                      rnd,
  input  logic                                  rnd_valid,
  output logic                                  rnd_ready,
  output logic [(security_order+1)*width-1:0]   out_shares,
  output logic                                  out_valid,
  input  logic                                  out_ready
);

  localparam int d     = security_order + 1;
  localparam int cnt_w = (d > 2) ? $clog2(d) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t               state_q, state_d;
  logic [width-1:0]     acc_q, acc_d;
  logic [cnt_w-1:0]     cnt_q, cnt_d;
  logic [width-1:0]     m_q [d-1];
  logic [width-1:0]     m_d [d-1];
  logic [d*width-1:0]   out_q, out_d;

  // Next-state and datapath: acc only ever holds the partially masked word;
  // the out register is loaded once, at the final rnd handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = in_data;
          cnt_d   = cnt_w'(1);
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (rnd_valid) begin
          acc_d = acc_q ^ rnd;
          for (int i = 0; i < d-1; i++) begin
            if (cnt_q == cnt_w'(i+1)) m_d[i] = rnd;
          end
          if (cnt_q == cnt_w'(d-1)) begin
            out_d[width-1:0] = acc_q ^ rnd;
            for (int i = 0; i < d-1; i++) begin
              out_d[(i+1)*width +: width] = m_d[i];
            end
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + cnt_w'(1);
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_d   = '0;
          acc_d   = '0;
          cnt_d   = '0;
          m_d     = '{default: '0};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, synchronously cleared by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      m_q     <= '{default: '0};
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      out_q   <= out_d;
    end
  end

  // Handshakes decode from state only; out_q is zero outside HOLD.
  assign in_ready   = (state_q == IDLE);
  assign rnd_ready  = (state_q == ACCUM);
  assign out_valid  = (state_q == HOLD);
  assign out_shares = out_q;

endmodule

// File: tb/tb_mask_share_encoder.sv
// Bench for mask_share_encoder: directed scenarios on a d=3 and a d=2
// instance, then a randomized run against a queue-based reference.
module tb_mask_share_encoder;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data, rnd;
  logic        in_valid, in_ready, rnd_valid, rnd_ready, out_valid, out_ready;
  logic [23:0] out_shares;

  logic [7:0]  b_in_data, b_rnd;
  logic        b_in_valid, b_in_ready, b_rnd_valid, b_rnd_ready, b_out_valid, b_out_ready;
  logic [15:0] b_out_shares;

  int vectors = 0;
  int miscompares = 0;

  mask_share_encoder #(.security_order(2), .width(8)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .out_shares(out_shares), .out_valid(out_valid), .out_ready(out_ready)
  );

  mask_share_encoder #(.security_order(1), .width(8)) dut_o1 (
    .clk(clk), .rst(rst),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .rnd(b_rnd), .rnd_valid(b_rnd_valid), .rnd_ready(b_rnd_ready),
    .out_shares(b_out_shares), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step past the next rising edge; inputs set afterwards apply to the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference share set for d=3: masks in arrival order, share 0 absorbs all.
  function automatic logic [23:0] ref3(input logic [7:0] data, input logic [7:0] r1,
                                       input logic [7:0] r2);
    return {r2, r1, data ^ r1 ^ r2};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({in_ready, rnd_ready, out_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_hs: got %b want 100", {in_ready, rnd_ready, out_valid});
    end
    vectors++;
    if (out_shares !== 24'h0) begin
      miscompares++;
      $display("FAIL reset_shares: got %h want 000000", out_shares);
    end
    vectors++;
    if ({b_in_ready, b_rnd_ready, b_out_valid, b_out_shares} !== {3'b100, 16'h0}) begin
      miscompares++;
      $display("FAIL reset_o1: got %b/%h want 100/0000",
               {b_in_ready, b_rnd_ready, b_out_valid}, b_out_shares);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [23:0] exp;
    exp = ref3(8'hA5, 8'h3C, 8'h5F);
    in_valid = 1'b1; in_data = 8'hA5; rnd_valid = 1'b1; rnd = 8'h3C;
    tick();  // E0
    in_valid = 1'b0;
    vectors++;
    if ({in_ready, rnd_ready, out_valid} !== 3'b010) begin
      miscompares++;
      $display("FAIL basic_e0_hs: got %b want 010", {in_ready, rnd_ready, out_valid});
    end
    tick();  // E1
    rnd = 8'h5F;
    vectors++;
    if (out_valid !== 1'b0 || out_shares !== 24'h0) begin
      miscompares++;
      $display("FAIL basic_e1_hidden: got v=%b s=%h want v=0 s=000000", out_valid, out_shares);
    end
    tick();  // E2
    rnd_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_shares !== exp) begin
      miscompares++;
      $display("FAIL basic_e2_out: got v=%b s=%h want v=1 s=%h", out_valid, out_shares, exp);
    end
    vectors++;
    if ((out_shares[7:0] ^ out_shares[15:8] ^ out_shares[23:16]) !== 8'hA5) begin
      miscompares++;
      $display("FAIL basic_xor: got %h want a5",
               out_shares[7:0] ^ out_shares[15:8] ^ out_shares[23:16]);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if ({in_ready, out_valid, out_shares} !== {2'b10, 24'h0}) begin
      miscompares++;
      $display("FAIL basic_release: got in_ready=%b v=%b s=%h want 1/0/000000",
               in_ready, out_valid, out_shares);
    end
  endtask

  task automatic test_order1();
    b_in_valid = 1'b1; b_in_data = 8'hA5; b_rnd_valid = 1'b1; b_rnd = 8'h0F;
    tick();
    b_in_valid = 1'b0;
    vectors++;
    if ({b_rnd_ready, b_out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL o1_accum: got %b want 10", {b_rnd_ready, b_out_valid});
    end
    tick();
    b_rnd_valid = 1'b0;
    vectors++;
    if (b_out_valid !== 1'b1 || b_out_shares !== {8'h0F, 8'hA5 ^ 8'h0F}) begin
      miscompares++;
      $display("FAIL o1_out: got v=%b s=%h want v=1 s=0faa", b_out_valid, b_out_shares);
    end
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    vectors++;
    if ({b_in_ready, b_out_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL o1_release: got %b want 10", {b_in_ready, b_out_valid});
    end
  endtask

  task automatic test_rnd_stall();
    logic [23:0] exp;
    exp = ref3(8'hA5, 8'h3C, 8'h5F);
    in_valid = 1'b1; in_data = 8'hA5; rnd_valid = 1'b1; rnd = 8'h3C;
    tick();  // E0
    in_valid = 1'b0;
    tick();  // E1
    rnd_valid = 1'b0; rnd = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (rnd_ready !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold[%0d]: got rnd_ready=%b v=%b want 1/0", i, rnd_ready, out_valid);
      end
    end
    rnd_valid = 1'b1; rnd = 8'h5F;
    tick();  // E6
    rnd_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_shares !== exp) begin
      miscompares++;
      $display("FAIL stall_out: got v=%b s=%h want v=1 s=%h", out_valid, out_shares, exp);
    end
  endtask

  // Entered with the stall word still in HOLD.
  task automatic test_backpressure();
    logic [23:0] held, exp;
    held = ref3(8'hA5, 8'h3C, 8'h5F);
    exp  = ref3(8'h11, 8'h21, 8'h42);
    in_valid = 1'b1; in_data = 8'h11; rnd_valid = 1'b1; rnd = 8'h77;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (out_valid !== 1'b1 || out_shares !== held || in_ready !== 1'b0 || rnd_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_stable[%0d]: got v=%b s=%h ir=%b rr=%b want 1/%h/0/0",
                 i, out_valid, out_shares, in_ready, rnd_ready, held);
      end
    end
    rnd_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vectors++;
    if ({in_ready, rnd_ready, out_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL bp_idle: got %b want 100", {in_ready, rnd_ready, out_valid});
    end
    tick();  // 0x11 accepted here
    in_valid = 1'b0; rnd_valid = 1'b1; rnd = 8'h21;
    vectors++;
    if ({in_ready, rnd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_accept: got %b want 01", {in_ready, rnd_ready});
    end
    tick();
    rnd = 8'h42;
    tick();
    rnd_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_shares !== exp) begin
      miscompares++;
      $display("FAIL bp_next_word: got v=%b s=%h want v=1 s=%h", out_valid, out_shares, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_accum();
    in_valid = 1'b1; in_data = 8'hA5; rnd_valid = 1'b1; rnd = 8'h3C;
    tick();
    in_valid = 1'b0;
    tick();  // first rnd consumed
    rnd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({in_ready, rnd_ready, out_valid, out_shares} !== {3'b100, 24'h0}) begin
      miscompares++;
      $display("FAIL midrst_state: got %b s=%h want 100 s=000000",
               {in_ready, rnd_ready, out_valid}, out_shares);
    end
    in_valid = 1'b1; in_data = 8'h00; rnd_valid = 1'b1; rnd = 8'hFF;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rnd_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_shares !== 24'hFFFF00) begin
      miscompares++;
      $display("FAIL midrst_word: got v=%b s=%h want v=1 s=ffff00", out_valid, out_shares);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    logic [7:0]  word_q[$];
    logic [7:0]  rnd_q[$];
    logic [23:0] exp;
    int done = 0;
    int cyc  = 0;
    while (done < 1000 && cyc < 40000) begin
      vectors++;
      if (int'(in_ready) + int'(rnd_ready) + int'(out_valid) != 1) begin
        miscompares++;
        $display("FAIL rand_onehot cyc %0d: got %b want exactly one set",
                 cyc, {in_ready, rnd_ready, out_valid});
      end
      vectors++;
      if (!out_valid) begin
        if (out_shares !== 24'h0) begin
          miscompares++;
          $display("FAIL rand_zero cyc %0d: got %h want 000000", cyc, out_shares);
        end
      end else if (word_q.size() != 1 || rnd_q.size() != 2) begin
        miscompares++;
        $display("FAIL rand_count cyc %0d: got words=%0d rnds=%0d want 1/2",
                 cyc, word_q.size(), rnd_q.size());
      end else begin
        exp = ref3(word_q[0], rnd_q[0], rnd_q[1]);
        if (out_shares !== exp) begin
          miscompares++;
          $display("FAIL rand_shares cyc %0d: got %h want %h", cyc, out_shares, exp);
        end
      end
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 8'($urandom);
      rnd_valid = ($urandom_range(0, 3) != 0);
      rnd       = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      if (in_ready && in_valid) word_q.push_back(in_data);
      if (rnd_ready && rnd_valid) rnd_q.push_back(rnd);
      if (out_valid && out_ready) begin
        if (word_q.size() > 0) void'(word_q.pop_front());
        rnd_q.delete();
        done++;
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0;
    vectors++;
    if (done < 1000) begin
      miscompares++;
      $display("FAIL rand_timeout: got %0d words want 1000", done);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0; in_valid = 1'b0; rnd = '0; rnd_valid = 1'b0; out_ready = 1'b0;
    b_in_data = '0; b_in_valid = 1'b0; b_rnd = '0; b_rnd_valid = 1'b0; b_out_ready = 1'b0;
    test_reset();
    test_basic();
    test_order1();
    test_rnd_stall();
    test_backpressure();
    test_reset_mid_accum();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
